muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/rv32i_pkg.sv | 35 +++
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32 M-extension types: funct3 opcode enum, mul/div FSM states and
// helpers that decode operand signedness from the opcode.
package rv32i_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input muldiv_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle of the iterative multiply/divide unit.
interface muldiv_unit_if import rv32i_pkg::*; #(
  parameter int unsigned XLEN = 32
) ();

  logic            start;
  muldiv_op_t      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            ready;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output start, op, a, b, flush,
    input  ready, result_valid, result, zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output ready, result_valid, result, zero
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration on the {acc, opr} register pair: shift-add multiply step
// (LSB first, right shift) or restoring shift-subtract divide step.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] opr_i,
  input  logic [XLEN-1:0] mcand_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] opr_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, acc_i} + {1'b0, mcand_i};
    rem_sh = {acc_i, opr_i[XLEN-1]};
    diff   = rem_sh - {1'b0, mcand_i};
    acc_o  = acc_i;
    opr_o  = opr_i;
    if (is_div) begin
      // Borrow out of the top bit means the trial subtraction is restored.
      if (!diff[XLEN]) begin
        acc_o = diff[XLEN-1:0];
        opr_o = {opr_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = rem_sh[XLEN-1:0];
        opr_o = {opr_i[XLEN-2:0], 1'b0};
      end
    end else if (opr_i[0]) begin
      {acc_o, opr_o} = {sum, opr_i[XLEN-1:1]};
    end else begin
      {acc_o, opr_o} = {1'b0, acc_i, opr_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit: one step per cycle on operand
// magnitudes, sign fix-up on completion, divide-by-zero/overflow short-cut.
module muldiv_unit import rv32i_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  muldiv_op_t      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d, byp_q, byp_d;
  logic [XLEN-1:0] acc_q, acc_d, opr_q, opr_d, mcand_q, mcand_d;
  logic            ready_q, ready_d, valid_q, valid_d, zero_q, zero_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept, a_neg, b_neg, div0, ovf, calc_div;
  logic [XLEN-1:0] a_mag, b_mag, byp_res, step_acc, step_opr;
  logic [PW-1:0]   prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, done_res;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  assign calc_div = op_is_div(op_q);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (calc_div),
    .acc_i   (acc_q),
    .opr_i   (opr_q),
    .mcand_i (mcand_q),
    .acc_o   (step_acc),
    .opr_o   (step_opr)
  );

  // Request decode: magnitudes, sign flags and the two CALC short-cuts.
  always_comb begin
    accept  = bus.start && ready_q && !bus.flush;
    a_neg   = op_a_signed(bus.op) && bus.a[XLEN-1];
    b_neg   = op_b_signed(bus.op) && bus.b[XLEN-1];
    a_mag   = a_neg ? negate(bus.a) : bus.a;
    b_mag   = b_neg ? negate(bus.b) : bus.b;
    div0    = op_is_div(bus.op) && (bus.b == '0);
    ovf     = ((bus.op == MD_DIV) || (bus.op == MD_REM)) &&
              (bus.a == MOST_NEG) && (bus.b == '1);
    byp_res = '0;
    if (div0) begin
      byp_res = bus.op[1] ? bus.a : '1;
    end else if (ovf) begin
      byp_res = bus.op[1] ? '0 : bus.a;
    end
  end

  // Completion: sign correction and result select.
  always_comb begin
    prod   = {acc_q, opr_q};
    prod_s = (neg_a_q ^ neg_b_q) ? (~prod + PW'(1)) : prod;
    quo_s  = (neg_a_q ^ neg_b_q) ? negate(opr_q) : opr_q;
    rem_s  = neg_a_q ? negate(acc_q) : acc_q;
    unique case (op_q)
      MD_MUL:                      done_res = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: done_res = prod_s[PW-1:XLEN];
      MD_DIV, MD_DIVU:             done_res = quo_s;
      default:                     done_res = rem_s;
    endcase
    if (byp_q) done_res = acc_q;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    byp_d    = byp_q;
    acc_d    = acc_q;
    opr_d    = opr_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d    = bus.op;
          cnt_d   = CW'(XLEN);
          byp_d   = div0 || ovf;
          neg_a_d = a_neg && !(div0 || ovf);
          neg_b_d = b_neg && !(div0 || ovf);
          acc_d   = (div0 || ovf) ? byp_res : '0;
          opr_d   = a_mag;
          mcand_d = b_mag;
          state_d = (div0 || ovf) ? MD_DONE : MD_CALC;
        end
      end
      MD_CALC: begin
        acc_d = step_acc;
        opr_d = step_opr;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = MD_DONE;
      end
      MD_DONE: begin
        result_d = done_res;
        zero_d   = (done_res == '0);
        valid_d  = 1'b1;
        state_d  = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    // Flush drops any in-flight work and leaves the visible result untouched.
    if (bus.flush) begin
      state_d  = MD_IDLE;
      cnt_d    = '0;
      result_d = result_q;
      zero_d   = zero_q;
      valid_d  = 1'b0;
    end
    ready_d = (state_d == MD_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MUL;
      cnt_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      byp_q    <= 1'b0;
      acc_q    <= '0;
      opr_q    <= '0;
      mcand_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      byp_q    <= byp_d;
      acc_q    <= acc_d;
      opr_q    <= opr_d;
      mcand_q  <= mcand_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.ready        = ready_q;
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;
  assign bus.zero         = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Issue one request from an idle unit and wait (bounded) for its result.
  task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.result_valid) begin lat = k; break; end
    end
    res = bus.result;
    z   = bus.zero;
  endtask

  task automatic test_reset();
    logic [31:0] res; logic z; int lat;
    rst_n = 1'b0; bus.start = 1'b0; bus.flush = 1'b0;
    bus.op = MD_MUL; bus.a = '0; bus.b = '0;
    #12;
    n_checks++; if (bus.ready !== 1'b1) begin n_fails++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    n_checks++; if (bus.result_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", bus.result_valid); end
    n_checks++; if (bus.result !== 32'h0) begin n_fails++; $display("FAIL reset_result: got %h want 0", bus.result); end
    n_checks++; if (bus.zero !== 1'b1) begin n_fails++; $display("FAIL reset_zero: got %b want 1", bus.zero); end
    @(negedge clk);
    rst_n = 1'b1; bus.start = 1'b1; bus.op = MD_MUL; bus.a = 32'd2; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++; if (bus.ready !== 1'b0) begin n_fails++; $display("FAIL first_accept_ready: got %b want 0", bus.ready); end
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.result_valid) begin lat = k; break; end
    end
    n_checks++; if (bus.result !== 32'd6 || lat != 33) begin n_fails++; $display("FAIL first_mul: got %h lat %0d want 6 lat 33", bus.result, lat); end
  endtask

  task automatic test_mul_latency();
    int first_v = -1; int n_valid = 0; int rdy_bad = 0;
    logic [31:0] res = '0; logic z = 1'b1; logic rdy_at = 1'b0;
    bus.op = MD_MUL; bus.a = 32'd7; bus.b = 32'hFFFF_FFFD; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (bus.ready) rdy_bad++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.result_valid) begin
        n_valid++;
        if (first_v < 0) begin first_v = k; res = bus.result; z = bus.zero; rdy_at = bus.ready; end
      end
      if (k < 33 && bus.ready) rdy_bad++;
    end
    n_checks++; if (first_v != 33) begin n_fails++; $display("FAIL mul_latency: got %0d want 33", first_v); end
    n_checks++; if (n_valid != 1) begin n_fails++; $display("FAIL mul_valid_pulses: got %0d want 1", n_valid); end
    n_checks++; if (rdy_bad != 0) begin n_fails++; $display("FAIL mul_ready_busy: got %0d high cycles want 0", rdy_bad); end
    n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fails++; $display("FAIL mul_result: got %h want ffffffeb", res); end
    n_checks++; if (z !== 1'b0) begin n_fails++; $display("FAIL mul_zero: got %b want 0", z); end
    n_checks++; if (rdy_at !== 1'b1) begin n_fails++; $display("FAIL mul_ready_done: got %b want 1", rdy_at); end
  endtask

  task automatic test_mul_high();
    logic [31:0] res; logic z; int lat;
    run_op(MD_MULH, 32'h8000_0000, 32'h8000_0000, res, z, lat);
    n_checks++; if (res !== 32'h4000_0000 || lat != 33) begin n_fails++; $display("FAIL mulh: got %h lat %0d want 40000000 lat 33", res, lat); end
    run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, z, lat);
    n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fails++; $display("FAIL mulhu: got %h want fffffffe", res); end
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, z, lat);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL mulhsu: got %h want ffffffff", res); end
  endtask

  task automatic test_div();
    logic [31:0] res; logic z; int lat;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, res, z, lat);
    n_checks++; if (res !== 32'hFFFF_FFFD || lat != 33) begin n_fails++; $display("FAIL div: got %h lat %0d want fffffffd lat 33", res, lat); end
    run_op(MD_REM, 32'hFFFF_FFF9, 32'd2, res, z, lat);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL rem: got %h want ffffffff", res); end
    run_op(MD_DIVU, 32'd100, 32'd7, res, z, lat);
    n_checks++; if (res !== 32'd14) begin n_fails++; $display("FAIL divu: got %0d want 14", res); end
    run_op(MD_REMU, 32'd100, 32'd7, res, z, lat);
    n_checks++; if (res !== 32'd2) begin n_fails++; $display("FAIL remu: got %0d want 2", res); end
  endtask

  task automatic test_div_special();
    logic [31:0] res; logic z; int lat;
    run_op(MD_DIVU, 32'd5, 32'd0, res, z, lat);
    n_checks++; if (res !== 32'hFFFF_FFFF || lat != 1) begin n_fails++; $display("FAIL divu_by0: got %h lat %0d want ffffffff lat 1", res, lat); end
    run_op(MD_REMU, 32'd5, 32'd0, res, z, lat);
    n_checks++; if (res !== 32'd5 || lat != 1) begin n_fails++; $display("FAIL remu_by0: got %h lat %0d want 5 lat 1", res, lat); end
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, z, lat);
    n_checks++; if (res !== 32'h8000_0000 || lat != 1) begin n_fails++; $display("FAIL div_ovf: got %h lat %0d want 80000000 lat 1", res, lat); end
    run_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, z, lat);
    n_checks++; if (res !== 32'h0 || z !== 1'b1) begin n_fails++; $display("FAIL rem_ovf: got %h zero %b want 0 zero 1", res, z); end
  endtask

  task automatic test_ignore_start();
    int lat = -1; logic [31:0] mid_res = '1;
    bus.op = MD_DIVU; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin bus.start = 1'b1; bus.op = MD_MUL; bus.a = 32'd1000; bus.b = 32'd3; mid_res = bus.result; end
      if (k == 8) bus.start = 1'b0;
      if (bus.result_valid) begin lat = k; break; end
    end
    n_checks++; if (mid_res !== 32'h0) begin n_fails++; $display("FAIL busy_result_held: got %h want 0", mid_res); end
    n_checks++; if (bus.result !== 32'd14 || lat != 33) begin n_fails++; $display("FAIL busy_start_ignored: got %0d lat %0d want 14 lat 33", bus.result, lat); end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic z; int lat; int n_valid = 0;
    run_op(MD_MUL, 32'd9, 32'd9, res, z, lat);
    bus.op = MD_DIV; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (bus.result_valid) n_valid++;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    if (bus.result_valid) n_valid++;
    n_checks++; if (bus.ready !== 1'b1) begin n_fails++; $display("FAIL flush_ready: got %b want 1", bus.ready); end
    n_checks++; if (bus.result !== 32'd81) begin n_fails++; $display("FAIL flush_result_held: got %0d want 81", bus.result); end
    run_op(MD_MUL, 32'd3, 32'd4, res, z, lat);
    n_checks++; if (res !== 32'd12 || lat != 33) begin n_fails++; $display("FAIL after_flush_mul: got %0d lat %0d want 12 lat 33", res, lat); end
    bus.op = MD_DIVU; bus.a = 32'd50; bus.b = 32'd5; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    n_checks++; if (bus.ready !== 1'b1) begin n_fails++; $display("FAIL flush_start_ready: got %b want 1", bus.ready); end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.result_valid) n_valid++;
    end
    n_checks++; if (n_valid != 0) begin n_fails++; $display("FAIL flush_no_valid: got %0d pulses want 0", n_valid); end
    n_checks++; if (bus.result !== 32'd12) begin n_fails++; $display("FAIL flush_start_result: got %0d want 12", bus.result); end
  endtask

  task automatic test_back_to_back();
    int v1 = -1; int v2 = -1; logic [31:0] r2 = '0;
    bus.op = MD_MUL; bus.a = 32'd5; bus.b = 32'd6; bus.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (bus.result_valid) begin
        if (v1 < 0) v1 = k;
        else if (v2 < 0) begin v2 = k; r2 = bus.result; end
      end
      if (k == 67) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    n_checks++; if (v1 != 33) begin n_fails++; $display("FAIL b2b_first: got %0d want 33", v1); end
    n_checks++; if (v2 != 67) begin n_fails++; $display("FAIL b2b_second: got %0d want 67", v2); end
    n_checks++; if (r2 !== 32'd30) begin n_fails++; $display("FAIL b2b_result: got %0d want 30", r2); end
    for (int k = 1; k <= 40; k++) begin @(posedge clk); #1; end
  endtask

  task automatic test_async_reset();
    logic [31:0] res; logic z; int lat; int n_valid = 0; int rdy_bad = 0;
    run_op(MD_MUL, 32'd9, 32'd9, res, z, lat);
    bus.op = MD_DIVU; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.ready !== 1'b1) begin n_fails++; $display("FAIL async_rst_ready: got %b want 1", bus.ready); end
    n_checks++; if (bus.result !== 32'h0) begin n_fails++; $display("FAIL async_rst_result: got %h want 0", bus.result); end
    n_checks++; if (bus.zero !== 1'b1) begin n_fails++; $display("FAIL async_rst_zero: got %b want 1", bus.zero); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.result_valid) n_valid++;
      if (!bus.ready) rdy_bad++;
    end
    n_checks++; if (n_valid != 0 || rdy_bad != 0) begin n_fails++; $display("FAIL async_rst_after: got %0d valid %0d busy want 0 0", n_valid, rdy_bad); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mul_latency();
    test_mul_high();
    test_div();
    test_div_special();
    test_ignore_start();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
